// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the transmit and receive sides: FSM states,
// frame constants and the frame-building helpers.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;
  localparam int         PS2_SEQ_LEN    = 3;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  // Odd parity: data plus parity always carries an odd number of ones.
  function automatic logic ps2_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Everything after the start bit, LSB first: data[0..7], parity, stop.
  function automatic logic [PS2_FRAME_BITS-2:0] ps2_frame_tail(input logic [7:0] data);
    return {1'b1, ps2_parity(data), data};
  endfunction

endpackage

// File: rtl/ascii2scan.sv
// Combinational ASCII to scan-code-set-2 make-code lookup.
// Only lowercase letters, digits, space and CR map; everything else misses.
module ascii2scan
  import ps2_pkg::*;
(
  input  logic [7:0] in_ascii,
  output logic       hit,
  output logic [7:0] scan
);

  always_comb begin
    hit  = 1'b1;
    scan = 8'h00;
    case (in_ascii)
      8'h30: scan = 8'h45;
      8'h31: scan = 8'h16;
      8'h32: scan = 8'h1E;
      8'h33: scan = 8'h26;
      8'h34: scan = 8'h25;
      8'h35: scan = 8'h2E;
      8'h36: scan = 8'h36;
      8'h37: scan = 8'h3D;
      8'h38: scan = 8'h3E;
      8'h39: scan = 8'h46;
      8'h61: scan = 8'h1C;
      8'h62: scan = 8'h32;
      8'h63: scan = 8'h21;
      8'h64: scan = 8'h23;
      8'h65: scan = 8'h24;
      8'h66: scan = 8'h2B;
      8'h67: scan = 8'h34;
      8'h68: scan = 8'h33;
      8'h69: scan = 8'h43;
      8'h6A: scan = 8'h3B;
      8'h6B: scan = 8'h42;
      8'h6C: scan = 8'h4B;
      8'h6D: scan = 8'h3A;
      8'h6E: scan = 8'h31;
      8'h6F: scan = 8'h44;
      8'h70: scan = 8'h4D;
      8'h71: scan = 8'h15;
      8'h72: scan = 8'h2D;
      8'h73: scan = 8'h1B;
      8'h74: scan = 8'h2C;
      8'h75: scan = 8'h3C;
      8'h76: scan = 8'h2A;
      8'h77: scan = 8'h1D;
      8'h78: scan = 8'h22;
      8'h79: scan = 8'h35;
      8'h7A: scan = 8'h1A;
      ASCII_SPACE: scan = 8'h29;
      ASCII_CR:    scan = 8'h5A;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ascii2ps2_tx.sv
// PS/2 keyboard-device emulator: one ASCII character per handshake becomes
// make, F0, make as three device-to-host frames on ps2_clk/ps2_data.
module ascii2ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_ascii,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int BIT_W = $clog2(PS2_FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PS2_FRAME_BITS - 1);
  localparam logic [1:0]       BYTE_LAST = 2'(PS2_SEQ_LEN - 1);

  ps2_state_e state, state_nxt;

  logic [7:0]                ascii_q;
  logic [7:0]                code_q;
  logic                      hit;
  logic [7:0]                scan;
  logic [1:0]                byte_idx;
  logic [BIT_W-1:0]          bit_cnt;
  logic [DIV_W-1:0]          div_cnt;
  logic                      half_low;
  logic [GAP_W-1:0]          gap_cnt;
  logic [PS2_FRAME_BITS-2:0] shreg;
  logic [7:0]                next_byte;

  logic div_last, bit_last, gap_last, byte_last;
  logic frame_start;
  logic clk_nxt, data_nxt;

  ascii2scan u_ascii2scan (
    .in_ascii (ascii_q),
    .hit      (hit),
    .scan     (scan)
  );

  assign div_last  = (div_cnt == DIV_LAST);
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign byte_last = (byte_idx == BYTE_LAST);

  // The byte of the frame about to start: the make code straight from the
  // lookup when leaving LOAD, otherwise F0 after byte 0 and the make code after byte 1.
  assign next_byte = (state == LOAD) ? scan :
                     (byte_idx == 2'd0) ? PS2_BREAK : code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      state    <= state_nxt;
      ps2_clk  <= clk_nxt;
      ps2_data <= data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = (state == IDLE);
    busy        = (state != IDLE);
    done        = 1'b0;
    err         = 1'b0;
    frame_start = 1'b0;
    clk_nxt     = 1'b1;
    data_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        if (hit) begin
          state_nxt   = SEND;
          frame_start = 1'b1;
        end else begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND: begin
        clk_nxt  = ps2_clk;
        data_nxt = ps2_data;
        if (div_last) begin
          if (!half_low) begin
            clk_nxt = 1'b0;
          end else if (bit_last) begin
            state_nxt = GAP;
            clk_nxt   = 1'b1;
            data_nxt  = 1'b1;
          end else begin
            clk_nxt  = 1'b1;
            data_nxt = shreg[0];
          end
        end
      end
      GAP: begin
        if (gap_last) begin
          if (byte_last) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt   = SEND;
            frame_start = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Every frame opens with the start bit while the clock is still high.
    if (frame_start) begin
      clk_nxt  = 1'b1;
      data_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ascii_q  <= 8'h00;
      code_q   <= 8'h00;
      byte_idx <= 2'd0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      half_low <= 1'b0;
      gap_cnt  <= '0;
      shreg    <= '1;
    end else begin
      if (state == IDLE && in_valid) ascii_q <= in_ascii;

      if (state == LOAD) begin
        code_q   <= scan;
        byte_idx <= 2'd0;
      end else if (state == GAP && gap_last && !byte_last) begin
        byte_idx <= byte_idx + 2'd1;
      end

      if (frame_start) begin
        shreg    <= ps2_frame_tail(next_byte);
        bit_cnt  <= '0;
        div_cnt  <= '0;
        half_low <= 1'b0;
      end else if (state == SEND) begin
        if (div_last) begin
          div_cnt  <= '0;
          half_low <= ~half_low;
          if (half_low && !bit_last) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            shreg   <= {1'b1, shreg[PS2_FRAME_BITS-2:1]};
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_ascii2ps2_tx.sv
// Randomised self-checking bench for ascii2ps2_tx: decodes the PS/2 frames
// on the wire and compares them with a lookup-table model of the keyboard.
module tb_ascii2ps2_tx;

  localparam int D_M = 4;
  localparam int G_M = 8;
  localparam int D_S = 2;
  localparam int G_S = 1;

  localparam logic [7:0] DIGIT_CODES [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                              8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] LETTER_CODES [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                               8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                               8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_m = 1'b0, in_valid_s = 1'b0;
  logic [7:0] in_ascii_m = 8'h00, in_ascii_s = 8'h00;
  logic       in_ready_m, busy_m, done_m, err_m, ps2_clk_m, ps2_data_m;
  logic       in_ready_s, busy_s, done_s, err_s, ps2_clk_s, ps2_data_s;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic       bits_q [$];
  int         fall_q [$];
  int         done_q [$];
  int         err_q  [$];
  int         gaps_q [$];
  logic [7:0] exp_q  [$];
  int busy_cnt, low_cnt, stab_err, excl_err, ready_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascii2ps2_tx #(.CLK_DIV(D_M), .GAP_CYCLES(G_M)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m),
    .in_ascii(in_ascii_m), .ps2_clk(ps2_clk_m), .ps2_data(ps2_data_m),
    .busy(busy_m), .done(done_m), .err(err_m)
  );

  ascii2ps2_tx #(.CLK_DIV(D_S), .GAP_CYCLES(G_S)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_ascii(in_ascii_s), .ps2_clk(ps2_clk_s), .ps2_data(ps2_data_s),
    .busy(busy_s), .done(done_s), .err(err_s)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Keyboard model: {hit, make code} straight from the scan-code table.
  function automatic logic [8:0] ref_map(input logic [7:0] c);
    int v = int'(c);
    if (v >= 48 && v <= 57)  return {1'b1, DIGIT_CODES[v - 48]};
    if (v >= 97 && v <= 122) return {1'b1, LETTER_CODES[v - 97]};
    if (v == 32)             return {1'b1, 8'h29};
    if (v == 13)             return {1'b1, 8'h5A};
    return 9'h000;
  endfunction

  task automatic sample(input int sel, output logic c, output logic d, output logic rdy,
                        output logic bsy, output logic dn, output logic er);
    if (sel == 0) begin
      c = ps2_clk_m; d = ps2_data_m; rdy = in_ready_m; bsy = busy_m; dn = done_m; er = err_m;
    end else begin
      c = ps2_clk_s; d = ps2_data_s; rdy = in_ready_s; bsy = busy_s; dn = done_s; er = err_s;
    end
  endtask

  // Waits for in_ready, offers one character and returns T, the accept edge
  // in the same cycle numbering as the wire samples (LOAD is cycle T+1).
  task automatic sendChar(input int sel, input logic [7:0] ch, input bit hold, output int t0);
    logic c, d, rdy, bsy, dn, er;
    int waited = 0;
    @(negedge clk);
    sample(sel, c, d, rdy, bsy, dn, er);
    while (!rdy && waited < 1000) begin
      @(negedge clk);
      sample(sel, c, d, rdy, bsy, dn, er);
      waited++;
    end
    checkOutput("ready_before_send", rdy, 1);
    if (sel == 0) begin in_valid_m = 1'b1; in_ascii_m = ch; end
    else          begin in_valid_s = 1'b1; in_ascii_s = ch; end
    @(negedge clk);
    if (!hold) begin
      if (sel == 0) in_valid_m = 1'b0;
      else          in_valid_s = 1'b0;
    end
    t0 = cyc - 1;
    sample(sel, c, d, rdy, bsy, dn, er);
    checkOutput("accept_busy", bsy, 1);
  endtask

  // Watches the wire once per cycle until the requested number of done
  // pulses has been seen and in_ready is back.
  task automatic capture(input int sel, input int n_done);
    logic c, d, rdy, bsy, dn, er;
    logic pc = 1'b1, pd = 1'b1;
    int run = 0;
    int n = 0;
    bits_q.delete(); fall_q.delete(); done_q.delete(); err_q.delete(); gaps_q.delete();
    busy_cnt = 0; low_cnt = 0; stab_err = 0; excl_err = 0; ready_cyc = -1;
    forever begin
      sample(sel, c, d, rdy, bsy, dn, er);
      if (pc && !c) begin bits_q.push_back(d); fall_q.push_back(cyc); end
      if (!pc && !c && d !== pd) stab_err++;
      if (dn) done_q.push_back(cyc);
      if (er) err_q.push_back(cyc);
      if (bsy) busy_cnt++;
      if (rdy && bsy) excl_err++;
      if (!c || !d) low_cnt++;
      if (c && d) run++;
      else begin
        if (c && !d && pc && pd) gaps_q.push_back(run);
        run = 0;
      end
      pc = c;
      pd = d;
      if (rdy && done_q.size() >= n_done) begin
        ready_cyc = cyc;
        break;
      end
      if (n >= 4000) begin
        checkOutput("capture_timeout", rdy, 1);
        break;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic checkFrames();
    int nf = exp_q.size();
    checkOutput("bit_count", bits_q.size(), 11 * nf);
    for (int f = 0; f < nf; f++) begin
      logic [10:0] fr;
      logic [7:0]  eb;
      for (int b = 0; b < 11; b++)
        fr[b] = (11 * f + b < bits_q.size()) ? bits_q[11 * f + b] : 1'bx;
      eb = exp_q[f];
      checkOutput($sformatf("f%0d_start", f), fr[0], 0);
      checkOutput($sformatf("f%0d_byte", f), fr[8:1], eb);
      checkOutput($sformatf("f%0d_parity", f), fr[9], ($countones(eb) % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("f%0d_stop", f), fr[10], 1);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] ch);
    int d   = (sel == 0) ? D_M : D_S;
    int g   = (sel == 0) ? G_M : G_S;
    int seq = 3 * (22 * d + g);
    logic [8:0] r = ref_map(ch);
    int t0;
    sendChar(sel, ch, 1'b0, t0);
    capture(sel, r[8] ? 1 : 0);
    if (r[8]) begin
      exp_q.delete();
      exp_q.push_back(r[7:0]); exp_q.push_back(8'hF0); exp_q.push_back(r[7:0]);
      checkFrames();
      checkOutput("first_fall", (fall_q.size() > 0) ? fall_q[0] : -1, t0 + 2 + d);
      checkOutput("done_count", done_q.size(), 1);
      checkOutput("done_cycle", (done_q.size() > 0) ? done_q[0] : -1, t0 + 1 + seq);
      checkOutput("ready_cycle", ready_cyc, t0 + 2 + seq);
      checkOutput("busy_cycles", busy_cnt, 1 + seq);
      checkOutput("gap1", (gaps_q.size() > 1) ? gaps_q[1] : -1, g);
      checkOutput("gap2", (gaps_q.size() > 2) ? gaps_q[2] : -1, g);
      checkOutput("err_count", err_q.size(), 0);
    end else begin
      checkOutput("miss_err_count", err_q.size(), 1);
      checkOutput("miss_err_cycle", (err_q.size() > 0) ? err_q[0] : -1, t0 + 1);
      checkOutput("miss_ready_cycle", ready_cyc, t0 + 2);
      checkOutput("miss_busy_cycles", busy_cnt, 1);
      checkOutput("miss_line_low", low_cnt, 0);
      checkOutput("miss_done_count", done_q.size(), 0);
    end
    checkOutput("data_stable_low", stab_err, 0);
    checkOutput("ready_busy_excl", excl_err, 0);
  endtask

  initial begin
    int t0;
    int seq_m = 3 * (22 * D_M + G_M);
    string pool = "0123456789abcdefghijklmnopqrstuvwxyz";
    logic [7:0] ch;
    int idx;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    checkOutput("rst_ps2_clk", ps2_clk_m, 1);
    checkOutput("rst_ps2_data", ps2_data_m, 1);
    checkOutput("rst_in_ready", in_ready_m, 1);
    checkOutput("rst_busy", busy_m, 0);
    checkOutput("rst_done", done_m, 0);
    checkOutput("rst_err", err_m, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 8'h61);
    applyStimulus(0, 8'h30);
    applyStimulus(0, 8'h41);

    // Back-to-back 'z' then CR with in_valid held throughout.
    sendChar(0, 8'h7A, 1'b1, t0);
    in_ascii_m = 8'h0D;
    capture(0, 2);
    in_valid_m = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h1A); exp_q.push_back(8'hF0); exp_q.push_back(8'h1A);
    exp_q.push_back(8'h5A); exp_q.push_back(8'hF0); exp_q.push_back(8'h5A);
    checkFrames();
    checkOutput("b2b_done_count", done_q.size(), 2);
    checkOutput("b2b_done0", (done_q.size() > 0) ? done_q[0] : -1, t0 + 1 + seq_m);
    checkOutput("b2b_done1", (done_q.size() > 1) ? done_q[1] : -1, t0 + 3 + 2 * seq_m);
    checkOutput("b2b_gap_between", (gaps_q.size() > 3) ? (gaps_q[3] >= G_M) : 0, 1);
    checkOutput("b2b_gap_in", (gaps_q.size() > 5) ? gaps_q[5] : -1, G_M);
    checkOutput("b2b_stable", stab_err, 0);

    // Reset in the low phase of data bit 3 of the F0 frame.
    sendChar(0, 8'h61, 1'b0, t0);
    while (cyc < t0 + 2 + (22 * D_M + G_M) + 4 * 2 * D_M + D_M) @(negedge clk);
    checkOutput("midframe_clk", ps2_clk_m, 0);
    checkOutput("midframe_data", ps2_data_m, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_clk", ps2_clk_m, 1);
    checkOutput("abort_data", ps2_data_m, 1);
    checkOutput("abort_busy", busy_m, 0);
    checkOutput("abort_ready", in_ready_m, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 8'h62);

    applyStimulus(1, 8'h6D);

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, 37);
        if (idx < 36)       ch = pool[idx];
        else if (idx == 36) ch = 8'h20;
        else                ch = 8'h0D;
      end else begin
        ch = 8'($urandom_range(0, 255));
      end
      applyStimulus(i % 3 == 2 ? 1 : 0, ch);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
